dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
Sequences MEM-stage data-memory accesses onto a variable-latency req/ack memory port.
- Freezes the rest of the pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) while an access is outstanding.
- Releases the pipeline for exactly one cycle when the access completes.
- Sits between the EX/MEM register outputs and Data_Memory, replacing the single-cycle access path; the top level routes stall_o to every pipeline register's hold enable.

Parameters:
DATA_W, 32, data and address width
TIMEOUT, 255, max cycles in ACCESS awaiting mem_ack_i before abort (>=1)
CNT_W, 8, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  reset, synchronous, active-low
MemRead_i  in  1  MEM-stage load request
MemWrite_i  in  1  MEM-stage store request
addr_i  in  DATA_W  MEM-stage ALU result (byte address)
wdata_i  in  DATA_W  MEM-stage store data
mem_req_o  out  1  memory request, registered
mem_we_o  out  1  1 = write, registered
mem_addr_o  out  DATA_W  latched address
mem_wdata_o  out  DATA_W  latched store data
mem_ack_i  in  1  memory completion, one-cycle pulse
mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i
rdata_o  out  DATA_W  load result to MEM/WB, registered
stall_o  out  1  pipeline freeze, combinational
err_o  out  1  sticky error flag

Behaviour:
- Reset: synchronous, active-low; sampled at the clock edge while rst_i=0. Next state is IDLE. All registered outputs clear to 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, rdata_o, err_o. Timeout counter clears to 0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - stall_o = MemRead_i | MemWrite_i (same cycle, combinational).
  - On request: latch addr_i and wdata_i. Set mem_we_o = MemWrite_i. Set mem_req_o = 1. Clear counter. Go to ACCESS.
  - MemRead_i and MemWrite_i both high: treat as write and set err_o.
  - mem_ack_i in IDLE is ignored.
- ACCESS:
  - stall_o = 1; mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o held stable.
  - Counter increments each cycle.
  - mem_ack_i = 1: drop mem_req_o. If read, rdata_o <= mem_rdata_i. Go to DONE.
  - Counter reaches TIMEOUT with no ack: drop mem_req_o, rdata_o <= 0, set err_o, go to DONE.
  - An ack in the same cycle as the timeout wins; no error is raised.
- DONE:
  - stall_o = 0. The pipeline advances, consuming rdata_o into MEM/WB.
  - MemRead_i/MemWrite_i are ignored this cycle because they still belong to the finished instruction.
  - Go to IDLE unconditionally.
- Latency: request first visible in cycle N. mem_req_o is high from N+1. Ack in cycle N+k (k>=1) gives DONE and valid rdata_o in N+k+1.
- Minimum cost of an access is 2 stall cycles.
- Back-to-back memory instructions: each pays the full sequence. A new request is accepted only in IDLE, never in DONE.
- rdata_o holds its value until the next completed read. Writes leave rdata_o unchanged.
- err_o is cleared only by reset.
- Reset mid-ACCESS: mem_req_o drops on that edge. The pending access is abandoned and no rdata_o update occurs.

Optional Feature:
DMEM_STATS_EN
- Defined: adds outputs stall_cnt_o[31:0] and access_cnt_o[31:0], both cleared by reset.
  - stall_cnt_o increments every cycle stall_o=1.
  - access_cnt_o increments on each ACCESS→DONE transition, including timeouts.
  - Both counters wrap modulo 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load, ack latency 1: MemRead_i=1, addr_i=0x10, mem_rdata_i=0xDEADBEEF with ack in N+1 -> mem_req_o high in N+1 only, stall_o=1 in N and N+1, 0 in N+2, rdata_o=0xDEADBEEF from N+2, mem_we_o=0.
- Store, ack latency 3: MemWrite_i=1, addr_i=0x20, wdata_i=0x12345678 -> mem_we_o=1, mem_addr_o=0x20, mem_wdata_o=0x12345678 stable N+1..N+3, stall_o=1 for N..N+3, rdata_o unchanged.
- Back-to-back loads, ack latency 1: two consecutive loads -> second mem_req_o rises at N+4 (one DONE, one IDLE between), 4 stall cycles total, no request in DONE.
- Timeout: TIMEOUT=4, load, no ack -> mem_req_o high N+1..N+4, DONE at N+5, rdata_o=0, err_o=1 held until reset.
- Reset mid-access: rst_i=0 in N+2 of a pending load -> mem_req_o=0, stall_o=0, state IDLE in N+3; late ack ignored; rdata_o=0.
- Illegal both: MemRead_i=MemWrite_i=1 -> mem_we_o=1, err_o=1. With DMEM_STATS_EN defined, access_cnt_o increments by 1.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences MEM-stage loads and stores onto a variable-latency
// req/ack data-memory port and freezes the pipeline while an access is outstanding.
// Optional statistics counters are enabled by defining DMEM_STATS_EN.
module dmem_access_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              err_o
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       access_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                req_any;
  logic                stall;

  assign req_any = MemRead_i | MemWrite_i;
  assign cnt_inc = cnt_q + 1'b1;

  // Pipeline freeze: raised in IDLE the same cycle a request appears, held
  // through ACCESS, released for the single DONE cycle.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      S_IDLE:   stall = req_any;
      S_ACCESS: stall = 1'b1;
      default:  stall = 1'b0;
    endcase
  end

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        // Any mem_ack_i seen here is stray and deliberately ignored.
        if (req_any) begin
          mem_addr_d  = addr_i;
          mem_wdata_d = wdata_i;
          mem_we_d    = MemWrite_i;   // read+write together is treated as a write
          mem_req_d   = 1'b1;
          cnt_d       = '0;
          if (MemRead_i && MemWrite_i) begin
            err_d = 1'b1;
          end
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_inc;
        // Ack takes priority over a timeout landing in the same cycle.
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            rdata_d = mem_rdata_i;
          end
          state_d = S_DONE;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          mem_req_d = 1'b0;
          rdata_d   = '0;
          err_d     = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        // Request lines still belong to the finished instruction; ignore them.
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign stall_o     = stall;

`ifdef DMEM_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] access_cnt_q, access_cnt_d;

  // Statistics: stall cycles and completed (or timed-out) accesses, wrapping.
  always_comb begin
    stall_cnt_d  = stall_cnt_q + {31'd0, stall};
    access_cnt_d = access_cnt_q +
                   {31'd0, (state_q == S_ACCESS) && (state_d == S_DONE)};
  end

  // Statistics counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_q  <= '0;
      access_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      access_cnt_q <= access_cnt_d;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign access_cnt_o = access_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed testbench for dmem_access_ctrl (built with TIMEOUT=4).
module tb_dmem_access_ctrl;
  localparam int DATA_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              MemRead_i, MemWrite_i;
  logic [DATA_W-1:0] addr_i, wdata_i;
  logic              mem_req_o, mem_we_o;
  logic [DATA_W-1:0] mem_addr_o, mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic [DATA_W-1:0] rdata_o;
  logic              stall_o, err_o;
`ifdef DMEM_STATS_EN
  logic [31:0]       stall_cnt_o, access_cnt_o;
`endif

  int checks = 0;
  int failures = 0;

  dmem_access_ctrl #(.DATA_W(DATA_W), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .rdata_o(rdata_o), .stall_o(stall_o), .err_o(err_o)
`ifdef DMEM_STATS_EN
    , .stall_cnt_o(stall_cnt_o), .access_cnt_o(access_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; idle_inputs(); addr_i = '0; wdata_i = '0; mem_rdata_i = '0;
    step(); step();
    #1;
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%0h exp=0", mem_req_o); end
    checks++; if (mem_we_o !== 1'b0) begin failures++; $display("FAIL rst_we got=%0h exp=0", mem_we_o); end
    checks++; if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin failures++; $display("FAIL rst_addr_wdata got=%0h/%0h exp=0/0", mem_addr_o, mem_wdata_o); end
    checks++; if (rdata_o !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%0h exp=0", rdata_o); end
    checks++; if (err_o !== 1'b0 || stall_o !== 1'b0) begin failures++; $display("FAIL rst_err_stall got=%0h/%0h exp=0/0", err_o, stall_o); end
`ifdef DMEM_STATS_EN
    checks++; if (stall_cnt_o !== 32'd0 || access_cnt_o !== 32'd0) begin failures++; $display("FAIL rst_stats got=%0d/%0d exp=0/0", stall_cnt_o, access_cnt_o); end
`endif
    step();
    rst_i = 1'b1;
    $display("txn reset done");
  endtask

  task automatic test_idle_ack_ignored();
    step();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    step();
    mem_ack_i = 1'b0; #1;
    checks++; if (rdata_o !== 32'h0 || mem_req_o !== 1'b0) begin failures++; $display("FAIL idle_ack rdata/req got=%0h/%0h exp=0/0", rdata_o, mem_req_o); end
    $display("txn idle stray ack");
  endtask

  task automatic test_load_lat1();
    step();                                   // cycle N
    MemRead_i = 1'b1; addr_i = 32'h10; #1;
    checks++; if (stall_o !== 1'b1 || mem_req_o !== 1'b0) begin failures++; $display("FAIL load_n stall/req got=%0h/%0h exp=1/0", stall_o, mem_req_o); end
    step();                                   // N+1
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF; #1;
    checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h10) begin failures++; $display("FAIL load_n1 req/we/addr got=%0h/%0h/%0h exp=1/0/10", mem_req_o, mem_we_o, mem_addr_o); end
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL load_n1 stall got=%0h exp=1", stall_o); end
    step();                                   // N+2 (DONE), MemRead still asserted
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0; #1;
    checks++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin failures++; $display("FAIL load_n2 req/stall got=%0h/%0h exp=0/0", mem_req_o, stall_o); end
    checks++; if (rdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL load_n2 rdata got=%0h exp=deadbeef", rdata_o); end
    MemRead_i = 1'b0;
    step();                                   // N+3 IDLE
    #1;
    checks++; if (mem_req_o !== 1'b0 || rdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL load_n3 req/rdata got=%0h/%0h exp=0/deadbeef", mem_req_o, rdata_o); end
    $display("txn load addr=10 lat=1 rdata=%0h", rdata_o);
  endtask

  task automatic test_store_lat3();
    step();                                   // N
    MemWrite_i = 1'b1; addr_i = 32'h20; wdata_i = 32'h12345678; #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL store_n stall got=%0h exp=1", stall_o); end
    for (int c = 1; c <= 3; c++) begin        // N+1..N+3
      step();
      addr_i = 32'hFFFF0000; wdata_i = 32'h0BADBAD0;   // must not disturb latched values
      if (c == 3) mem_ack_i = 1'b1;
      mem_rdata_i = 32'h99999999; #1;
      checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || stall_o !== 1'b1) begin failures++; $display("FAIL store_n%0d req/we/stall got=%0h/%0h/%0h exp=1/1/1", c, mem_req_o, mem_we_o, stall_o); end
      checks++; if (mem_addr_o !== 32'h20 || mem_wdata_o !== 32'h12345678) begin failures++; $display("FAIL store_n%0d addr/wdata got=%0h/%0h exp=20/12345678", c, mem_addr_o, mem_wdata_o); end
    end
    step();                                   // N+4 DONE
    mem_ack_i = 1'b0; #1;
    checks++; if (stall_o !== 1'b0 || mem_req_o !== 1'b0) begin failures++; $display("FAIL store_done stall/req got=%0h/%0h exp=0/0", stall_o, mem_req_o); end
    checks++; if (rdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL store_rdata got=%0h exp=deadbeef", rdata_o); end
    MemWrite_i = 1'b0;
    $display("txn store addr=20 wdata=12345678 lat=3");
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    step();                                   // N: first load
    MemRead_i = 1'b1; addr_i = 32'h40; #1;
    if (stall_o) stalls++;
    step();                                   // N+1: ack first
    mem_ack_i = 1'b1; mem_rdata_i = 32'hA5A5A5A5; #1;
    if (stall_o) stalls++;
    step();                                   // N+2: DONE, next load already presented
    mem_ack_i = 1'b0; addr_i = 32'h44; #1;
    if (stall_o) stalls++;
    checks++; if (mem_req_o !== 1'b0 || rdata_o !== 32'hA5A5A5A5) begin failures++; $display("FAIL b2b_done req/rdata got=%0h/%0h exp=0/a5a5a5a5", mem_req_o, rdata_o); end
    step();                                   // N+3: IDLE accepts second load
    #1;
    if (stall_o) stalls++;
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL b2b_n3 req got=%0h exp=0", mem_req_o); end
    step();                                   // N+4: second request visible
    mem_ack_i = 1'b1; mem_rdata_i = 32'h5A5A5A5A; #1;
    if (stall_o) stalls++;
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h44) begin failures++; $display("FAIL b2b_n4 req/addr got=%0h/%0h exp=1/44", mem_req_o, mem_addr_o); end
    step();                                   // N+5: DONE
    mem_ack_i = 1'b0; #1;
    if (stall_o) stalls++;
    MemRead_i = 1'b0;
    checks++; if (rdata_o !== 32'h5A5A5A5A) begin failures++; $display("FAIL b2b_rdata got=%0h exp=5a5a5a5a", rdata_o); end
    checks++; if (stalls != 4) begin failures++; $display("FAIL b2b_stall_count got=%0d exp=4", stalls); end
    $display("txn back-to-back loads stalls=%0d", stalls);
  endtask

  task automatic test_timeout();
    step();                                   // N
    MemRead_i = 1'b1; addr_i = 32'h30; #1;
    for (int c = 1; c <= 4; c++) begin        // N+1..N+4 no ack
      step(); #1;
      checks++; if (mem_req_o !== 1'b1 || stall_o !== 1'b1) begin failures++; $display("FAIL tmo_n%0d req/stall got=%0h/%0h exp=1/1", c, mem_req_o, stall_o); end
    end
    step(); #1;                               // N+5 DONE
    checks++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin failures++; $display("FAIL tmo_done req/stall got=%0h/%0h exp=0/0", mem_req_o, stall_o); end
    checks++; if (rdata_o !== 32'h0 || err_o !== 1'b1) begin failures++; $display("FAIL tmo_done rdata/err got=%0h/%0h exp=0/1", rdata_o, err_o); end
    MemRead_i = 1'b0;
    step(); step(); #1;
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL tmo_err_sticky got=%0h exp=1", err_o); end
    $display("txn load timeout err=%0h", err_o);
  endtask

  task automatic test_reset_mid_access();
    rst_i = 1'b0; step(); rst_i = 1'b1;       // clear err from timeout
    #1;
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL rst_clears_err got=%0h exp=0", err_o); end
    step();                                   // a completed load to make rdata nonzero
    MemRead_i = 1'b1; addr_i = 32'h50;
    step(); mem_ack_i = 1'b1; mem_rdata_i = 32'h11112222;
    step(); mem_ack_i = 1'b0; MemRead_i = 1'b0;
    step();
    MemRead_i = 1'b1; addr_i = 32'h54;        // N
    step();                                   // N+1 ACCESS
    step();                                   // N+2 reset asserted
    rst_i = 1'b0; MemRead_i = 1'b0;
    step();                                   // N+3
    rst_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h77777777; #1;
    checks++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin failures++; $display("FAIL rstmid_n3 req/stall got=%0h/%0h exp=0/0", mem_req_o, stall_o); end
    step();                                   // late ack must be ignored
    mem_ack_i = 1'b0; #1;
    checks++; if (rdata_o !== 32'h0 || mem_req_o !== 1'b0 || stall_o !== 1'b0) begin failures++; $display("FAIL rstmid_late_ack rdata/req/stall got=%0h/%0h/%0h exp=0/0/0", rdata_o, mem_req_o, stall_o); end
    $display("txn reset mid-access rdata=%0h", rdata_o);
  endtask

  task automatic test_illegal_both();
`ifdef DMEM_STATS_EN
    logic [31:0] acc0;
    logic [31:0] stl0;
`endif
    step();                                   // N
`ifdef DMEM_STATS_EN
    acc0 = access_cnt_o; stl0 = stall_cnt_o;
`endif
    MemRead_i = 1'b1; MemWrite_i = 1'b1; addr_i = 32'h60; wdata_i = 32'hFEEDFACE; #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL both_n stall got=%0h exp=1", stall_o); end
    step();                                   // N+1
    mem_ack_i = 1'b1; mem_rdata_i = 32'h33334444; #1;
    checks++; if (mem_we_o !== 1'b1 || err_o !== 1'b1) begin failures++; $display("FAIL both_we_err got=%0h/%0h exp=1/1", mem_we_o, err_o); end
    step();                                   // N+2 DONE
    mem_ack_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; #1;
    checks++; if (rdata_o !== 32'h0) begin failures++; $display("FAIL both_rdata got=%0h exp=0", rdata_o); end
`ifdef DMEM_STATS_EN
    checks++; if (access_cnt_o !== acc0 + 32'd1) begin failures++; $display("FAIL both_access_cnt got=%0d exp=%0d", access_cnt_o, acc0 + 32'd1); end
    checks++; if (stall_cnt_o !== stl0 + 32'd2) begin failures++; $display("FAIL both_stall_cnt got=%0d exp=%0d", stall_cnt_o, stl0 + 32'd2); end
`endif
    $display("txn illegal read+write err=%0h", err_o);
  endtask

  initial begin
    test_reset();
    test_idle_ack_ignored();
    test_load_lat1();
    test_store_lat3();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    test_illegal_both();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
